reg_file_sb: RTL

Parametrised integer register file for the RISC_V core with hazard tracking. It offers two combinational read ports and one synchronous write port, with register 0 hardwired to zero. A same-cycle write-to-read bypass and a per-register busy scoreboard let decode stall on in-flight destinations. It sits between decode (reads and issue) and writeback (write and busy clear).

---
 rtl/reg_file_sb.sv | 113 +++++++++++
 1 files changed

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - integer register file with write bypass and busy scoreboard
module reg_file_sb #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    rs1,
  input  logic [AW-1:0]    rs2,
  input  logic [AW-1:0]    rd,
  input  logic [WIDTH-1:0] data_des,
  input  logic             reg_wen,
  input  logic             iss_en,
  input  logic [AW-1:0]    iss_rd,
  input  logic             flush,
  output logic [WIDTH-1:0] dataA,
  output logic [WIDTH-1:0] dataB,
  output logic             validA,
  output logic             validB,
  output logic [AW:0]      busy_cnt
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;
  logic [AW:0]      cnt_q;
  logic [AW:0]      cnt_nxt;
  logic             set_new;
  logic             clr_new;
  logic             wr_act;
  logic             iss_act;

  assign wr_act  = reg_wen && (rd != '0);
  assign iss_act = iss_en && (iss_rd != '0);

  // Array write; entry 0 is never loaded so it reads as zero forever.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_act) begin
      mem[rd] <= data_des;
    end
  end

  // Next busy vector: flush beats issue, issue beats writeback clear.
  always_comb begin
    busy_nxt = busy;
    if (flush) begin
      busy_nxt = '0;
    end else begin
      if (wr_act)  busy_nxt[rd]     = 1'b0;
      if (iss_act) busy_nxt[iss_rd] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  // Count tracks only genuine bit transitions, so re-issuing a busy register
  // or writing an idle one leaves it alone.
  always_comb begin
    set_new = iss_act && !busy[iss_rd];
    clr_new = wr_act && busy[rd] && !(iss_act && (iss_rd == rd));
    if (flush) begin
      cnt_nxt = '0;
    end else begin
      cnt_nxt = cnt_q + {{AW{1'b0}}, set_new} - {{AW{1'b0}}, clr_new};
    end
  end

  // Scoreboard state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy  <= '0;
      cnt_q <= '0;
    end else begin
      busy  <= busy_nxt;
      cnt_q <= cnt_nxt;
    end
  end

  assign busy_cnt = cnt_q;

  // Port A read: reset forces zero, x0 is zero, then bypass, then array.
  always_comb begin
    dataA  = '0;
    validA = 1'b1;
    if (!rst && (rs1 != '0)) begin
      if (reg_wen && (rd == rs1)) begin
        dataA = data_des;
      end else begin
        dataA  = mem[rs1];
        validA = !busy[rs1];
      end
    end
  end

  // Port B read: same priority as port A.
  always_comb begin
    dataB  = '0;
    validB = 1'b1;
    if (!rst && (rs2 != '0)) begin
      if (reg_wen && (rd == rs2)) begin
        dataB = data_des;
      end else begin
        dataB  = mem[rs2];
        validB = !busy[rs2];
      end
    end
  end

endmodule
